prog_load_ctrl: RTL and testbench

- Boot/run sequencer for the RISC-V pipeline core.
- Accepts a program as a valid/ready word stream and writes it into core instruction memory through the core's load interface (start/address/instruction).
- Releases the core to run, then watches the data-memory readback port for the completion flag (mem[0]==1) and captures the result word (mem[1]).
- Keeps cycle, flush and branch counters, and bounds execution with a cycle timeout.

---
 rtl/prog_load_ctrl.sv | 147 ++++++++++++++
 tb/tb_prog_load_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_ctrl.sv
// Boot/run sequencer: streams a program into core instruction memory, releases the core,
// then waits for the completion flag in data memory and captures the result word.
module prog_load_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_go,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic [31:0]       max_cycles,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              start,
  output logic [31:0]       address,
  output logic [31:0]       instruction,
  output logic              DataOrReg,
  output logic [31:0]       check_address,
  input  logic [31:0]       value,
  input  logic              flush,
  input  logic              branch_e,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       result,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       branch_cnt
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StRead = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [31:0]       max_q, max_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [31:0]       flush_q, flush_d;
  logic [31:0]       branch_q, branch_d;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    max_d     = max_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    timeout_d = timeout_q;
    result_d  = result_q;
    cyc_d     = cyc_q;
    flush_d   = flush_q;
    branch_d  = branch_q;
    case (state_q)
      StIdle, StDone: begin
        if (cmd_go) begin
          len_d     = prog_len;
          max_d     = max_cycles;
          idx_d     = '0;
          cyc_d     = '0;
          flush_d   = '0;
          branch_d  = '0;
          timeout_d = 1'b0;
          result_d  = '0;
          state_d   = (prog_len == '0) ? StRun : StLoad;
        end
      end
      StLoad: begin
        // One extra LOAD cycle after the last beat presents the final write with start high.
        if (idx_q == len_q) begin
          state_d = StRun;
        end else if (ld_valid) begin
          addr_d  = idx_q[ADDR_W-1:0];
          instr_d = ld_data;
          idx_d   = idx_q + LEN_W'(1);
        end
      end
      StRun: begin
        if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
        if (flush && flush_q != '1) flush_d = flush_q + 32'd1;
        if (branch_e && branch_q != '1) branch_d = branch_q + 32'd1;
        if (value == 32'd1) begin
          state_d = StRead;
        end else if (max_q != '0 && cyc_q + 32'd1 == max_q) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StRead: begin
        result_d = value;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      addr_q    <= '0;
      instr_q   <= '0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      cyc_q     <= '0;
      flush_q   <= '0;
      branch_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      cyc_q     <= cyc_d;
      flush_q   <= flush_d;
      branch_q  <= branch_d;
    end
  end

  assign ld_ready      = (state_q == StLoad) && (idx_q != len_q);
  assign start         = (state_q != StRun);
  assign address       = {{(32-ADDR_W){1'b0}}, addr_q};
  assign instruction   = instr_q;
  assign DataOrReg     = 1'b1;
  assign check_address = (state_q == StRead) ? 32'd1 : 32'd0;
  assign busy          = (state_q == StLoad) || (state_q == StRun) || (state_q == StRead);
  assign done          = (state_q == StDone);
  assign timeout       = timeout_q;
  assign result        = result_q;
  assign cycle_cnt     = cyc_q;
  assign flush_cnt     = flush_q;
  assign branch_cnt    = branch_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomized self-checking bench for prog_load_ctrl against a transaction-level model of
// load, run and completion behaviour.
module tb_prog_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_go;
  logic [10:0] prog_len;
  logic [31:0] max_cycles;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        start;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        data_or_reg;
  logic [31:0] check_address;
  logic [31:0] value;
  logic        flush;
  logic        branch_e;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] result;
  logic [31:0] cycle_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] branch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Core memory model: mem[1] holds the result, mem[0] reads 1 only on the completion cycle.
  logic        flag_now;
  logic [31:0] res_word;
  logic [31:0] noise;
  logic [31:0] fixed_words [3];

  always_comb value = (check_address == 32'd1) ? res_word : (flag_now ? 32'd1 : noise);

  always #5 clk = ~clk;

  prog_load_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_go        (cmd_go),
    .prog_len      (prog_len),
    .max_cycles    (max_cycles),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .start         (start),
    .address       (address),
    .instruction   (instruction),
    .DataOrReg     (data_or_reg),
    .check_address (check_address),
    .value         (value),
    .flush         (flush),
    .branch_e      (branch_e),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .result        (result),
    .cycle_cnt     (cycle_cnt),
    .flush_cnt     (flush_cnt),
    .branch_cnt    (branch_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_start", start, 1);
    check_eq("rst_address", address, 0);
    check_eq("rst_instruction", instruction, 0);
    check_eq("rst_data_or_reg", data_or_reg, 1);
    check_eq("rst_check_address", check_address, 0);
    check_eq("rst_ld_ready", ld_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_cycle_cnt", cycle_cnt, 0);
    check_eq("rst_flush_cnt", flush_cnt, 0);
    check_eq("rst_branch_cnt", branch_cnt, 0);
  endtask

  // gap: 0 = ld_valid always high, 1 = high every other cycle, 2 = random 50%.
  // c_at: RUN cycle on which mem[0] reads 1 (0 = never); m: max_cycles.
  task automatic run_prog(input int len, input int gap, input int c_at, input int m,
                          input bit fixed, input bit fresh);
    int acc, guard, k, fl, br, stop_k;
    bit completed, accepted, fin;
    logic [31:0] wdata;
    res_word = $urandom;
    @(negedge clk);
    cmd_go     = 1'b1;
    prog_len   = 11'(len);
    max_cycles = 32'(m);
    @(negedge clk);
    cmd_go = 1'b0;
    if (len > 0) begin
      check_eq("busy_load", busy, 1);
      acc = 0;
      guard = 0;
      while (acc < len && guard < 3 * len + 20) begin
        check_eq("ld_ready_high", ld_ready, 1);
        check_eq("start_load", start, 1);
        case (gap)
          0:       ld_valid = 1'b1;
          1:       ld_valid = guard[0];
          default: ld_valid = 1'($urandom_range(0, 1));
        endcase
        wdata    = fixed ? fixed_words[acc] : $urandom;
        ld_data  = wdata;
        // cmd_go during LOAD must be ignored
        cmd_go   = ($urandom_range(0, 7) == 0);
        prog_len = 11'($urandom_range(1, 5));
        accepted = ld_valid;
        @(negedge clk);
        cmd_go = 1'b0;
        if (accepted) begin
          check_eq("wr_address", address, 32'(acc));
          check_eq("wr_instruction", instruction, wdata);
          acc++;
        end
        guard++;
      end
      check_eq("load_beats", 32'(acc), 32'(len));
      check_eq("ld_ready_drop", ld_ready, 0);
      check_eq("start_last_write", start, 1);
      check_eq("last_address", address, 32'(len - 1));
      ld_valid = 1'b1;
      ld_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      ld_valid = 1'b0;
    end else if (fresh) begin
      check_eq("len0_no_write_addr", address, 0);
      check_eq("len0_no_write_instr", instruction, 0);
    end
    k = 0;
    fl = 0;
    br = 0;
    fin = 1'b0;
    completed = 1'b0;
    stop_k = 0;
    while (!fin && k < 400) begin
      k++;
      check_eq("start_run", start, 0);
      check_eq("ld_ready_run", ld_ready, 0);
      flush    = 1'($urandom_range(0, 1));
      branch_e = 1'($urandom_range(0, 1));
      cmd_go   = ($urandom_range(0, 9) == 0);
      fl += int'(flush);
      br += int'(branch_e);
      flag_now = (k == c_at);
      noise    = 32'hA000_0000 | 32'($urandom_range(0, 255));
      if (k == c_at) begin
        fin = 1'b1;
        completed = 1'b1;
      end else if (m != 0 && k == m) begin
        fin = 1'b1;
      end
      stop_k = k;
      @(negedge clk);
    end
    flush = 1'b0;
    branch_e = 1'b0;
    cmd_go = 1'b0;
    flag_now = 1'b0;
    if (!fin) check_eq("run_bound_expired", 0, 1);
    if (completed) begin
      check_eq("read_check_address", check_address, 1);
      check_eq("read_start", start, 1);
      check_eq("read_busy", busy, 1);
      @(negedge clk);
    end
    check_eq("done", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_start", start, 1);
    check_eq("done_check_address", check_address, 0);
    check_eq("timeout", timeout, completed ? 0 : 1);
    check_eq("result", result, completed ? res_word : 0);
    check_eq("cycle_cnt", cycle_cnt, 32'(stop_k));
    check_eq("flush_cnt", flush_cnt, 32'(fl));
    check_eq("branch_cnt", branch_cnt, 32'(br));
    for (int i = 0; i < 2; i++) begin
      flush = 1'b1;
      branch_e = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    branch_e = 1'b0;
    check_eq("done_held", done, 1);
    check_eq("flush_cnt_frozen", flush_cnt, 32'(fl));
    check_eq("branch_cnt_frozen", branch_cnt, 32'(br));
    check_eq("cycle_cnt_frozen", cycle_cnt, 32'(stop_k));
  endtask

  initial begin
    int len, gap, c_at, m;
    fixed_words[0] = 32'h0050_0093;
    fixed_words[1] = 32'h0010_0113;
    fixed_words[2] = 32'h0000_006F;
    rst_n = 1'b0;
    cmd_go = 1'b0;
    prog_len = '0;
    max_cycles = '0;
    ld_valid = 1'b0;
    ld_data = '0;
    flush = 1'b0;
    branch_e = 1'b0;
    flag_now = 1'b0;
    res_word = '0;
    noise = 32'hA000_0000;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    run_prog(0, 0, 5, 0, 1'b0, 1'b1);
    run_prog(3, 0, 20, 0, 1'b1, 1'b0);
    run_prog(4, 1, 20, 0, 1'b0, 1'b0);
    run_prog(2, 0, 0, 50, 1'b0, 1'b0);
    run_prog(2, 0, 50, 50, 1'b0, 1'b0);

    // Reset mid-load after five accepted beats.
    @(negedge clk);
    cmd_go = 1'b1;
    prog_len = 11'd8;
    max_cycles = 32'd0;
    @(negedge clk);
    cmd_go = 1'b0;
    ld_valid = 1'b1;
    repeat (5) begin
      ld_data = $urandom;
      @(negedge clk);
    end
    check_eq("mid_load_address", address, 4);
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_prog(6, 2, 9, 0, 1'b0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      len  = $urandom_range(1, 16);
      gap  = $urandom_range(0, 2);
      c_at = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      m    = (c_at == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
      run_prog(len, gap, c_at, m, 1'b0, 1'b0);
    end

    run_prog(1024, 0, 3, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
